// File: rtl/div_seq_ctrl.sv
// div_seq_ctrl: multi-cycle DIV/DIVU sequencer for the EX stage.
// It performs restoring division by driving the shared single-cycle ALU
// (sub / sltu) one quotient bit at a time, with signed pre/post negation.
// Results land in internal HI/LO registers. The done pulse and the HI/LO
// write happen on the edge that leaves the DONE state.
module div_seq_ctrl #(
  parameter int unsigned W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic         is_signed,
  input  logic [W-1:0] dividend,
  input  logic [W-1:0] divisor,
  input  logic         abort,
  input  logic [W-1:0] alu_out,
  output logic [W-1:0] alu_a,
  output logic [W-1:0] alu_b,
  output logic [4:0]   alu_op,
  output logic         alu_sel,
  output logic         busy,
  output logic         done,
  output logic         div_by_zero,
  output logic [W-1:0] lo,
  output logic [W-1:0] hi
);

  localparam int unsigned CW = 5;
  localparam logic [4:0] OP_NOP  = 5'b00000;
  localparam logic [4:0] OP_SUB  = 5'b00001;
  localparam logic [4:0] OP_SLTU = 5'b01100;

  typedef enum logic [2:0] {
    S_IDLE, S_NEGA, S_NEGB, S_CMP, S_SUB, S_FIXQ, S_FIXR, S_DONE
  } state_t;

  state_t        state, state_n;
  logic [W-1:0]  n_q, n_n, d_q, d_n, r_q, r_n, q_q, q_n;
  logic [CW-1:0] cnt_q, cnt_n;
  logic          sgn_q, sgn_n, sq_q, sq_n, sr_q, sr_n;
  logic          take_q, take_n, zero_q, zero_n;
  logic [W-1:0]  s32, s32_n;
  logic [W-1:0]  lo_n, hi_n, alu_a_n, alu_b_n;
  logic [4:0]    alu_op_n;
  logic          alu_sel_n, busy_n, done_n, dbz_n;

  // Next-state, datapath and next registered-output computation
  always_comb begin
    state_n   = state;
    n_n       = n_q;
    d_n       = d_q;
    r_n       = r_q;
    q_n       = q_q;
    cnt_n     = cnt_q;
    sgn_n     = sgn_q;
    sq_n      = sq_q;
    sr_n      = sr_q;
    take_n    = take_q;
    zero_n    = zero_q;
    lo_n      = lo;
    hi_n      = hi;
    dbz_n     = div_by_zero;
    done_n    = 1'b0;
    alu_a_n   = '0;
    alu_b_n   = '0;
    alu_op_n  = OP_NOP;
    alu_sel_n = 1'b0;
    busy_n    = 1'b0;
    s32       = {r_q[W-2:0], n_q[cnt_q]};

    if (abort && (state != S_IDLE)) begin
      state_n = S_IDLE;
    end else begin
      case (state)
        S_IDLE: begin
          if (start && !abort) begin
            n_n    = dividend;
            d_n    = divisor;
            sgn_n  = is_signed;
            sq_n   = is_signed & (dividend[W-1] ^ divisor[W-1]);
            sr_n   = is_signed & dividend[W-1];
            r_n    = '0;
            q_n    = '0;
            cnt_n  = CW'(W - 1);
            zero_n = (divisor == '0);
            if (divisor == '0)  state_n = S_DONE;
            else if (is_signed) state_n = S_NEGA;
            else                state_n = S_CMP;
          end
        end
        S_NEGA: begin
          if (n_q[W-1]) n_n = alu_out;
          state_n = S_NEGB;
        end
        S_NEGB: begin
          if (d_q[W-1]) d_n = alu_out;
          state_n = S_CMP;
        end
        S_CMP: begin
          // A set top bit of R means the shifted remainder exceeds any divisor
          take_n  = r_q[W-1] | ~alu_out[0];
          state_n = S_SUB;
        end
        S_SUB: begin
          r_n        = take_q ? alu_out : s32;
          q_n[cnt_q] = take_q;
          if (cnt_q == '0) begin
            state_n = sgn_q ? S_FIXQ : S_DONE;
          end else begin
            cnt_n   = cnt_q - CW'(1);
            state_n = S_CMP;
          end
        end
        S_FIXQ: begin
          if (sq_q) q_n = alu_out;
          state_n = S_FIXR;
        end
        S_FIXR: begin
          if (sr_q) r_n = alu_out;
          state_n = S_DONE;
        end
        S_DONE: begin
          done_n = 1'b1;
          if (zero_q) begin
            lo_n  = '1;
            hi_n  = n_q;
            dbz_n = 1'b1;
          end else begin
            lo_n  = q_q;
            hi_n  = r_q;
            dbz_n = 1'b0;
          end
          state_n = S_IDLE;
        end
        default: state_n = S_IDLE;
      endcase
    end

    // ALU drive for the state being entered, built from next datapath values
    s32_n = {r_n[W-2:0], n_n[cnt_n]};
    case (state_n)
      S_NEGA: begin alu_op_n = OP_SUB;  alu_b_n = n_n; end
      S_NEGB: begin alu_op_n = OP_SUB;  alu_b_n = d_n; end
      S_CMP:  begin alu_op_n = OP_SLTU; alu_a_n = s32_n; alu_b_n = d_n; end
      S_SUB:  begin alu_op_n = OP_SUB;  alu_a_n = s32_n; alu_b_n = d_n; end
      S_FIXQ: begin alu_op_n = OP_SUB;  alu_b_n = q_n; end
      S_FIXR: begin alu_op_n = OP_SUB;  alu_b_n = r_n; end
      default: alu_op_n = OP_NOP;
    endcase
    alu_sel_n = (state_n != S_IDLE) && (state_n != S_DONE);
    busy_n    = alu_sel_n;
  end

  // State, datapath and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      n_q         <= '0;
      d_q         <= '0;
      r_q         <= '0;
      q_q         <= '0;
      cnt_q       <= '0;
      sgn_q       <= 1'b0;
      sq_q        <= 1'b0;
      sr_q        <= 1'b0;
      take_q      <= 1'b0;
      zero_q      <= 1'b0;
      lo          <= '0;
      hi          <= '0;
      div_by_zero <= 1'b0;
      done        <= 1'b0;
      busy        <= 1'b0;
      alu_sel     <= 1'b0;
      alu_a       <= '0;
      alu_b       <= '0;
      alu_op      <= OP_NOP;
    end else begin
      state       <= state_n;
      n_q         <= n_n;
      d_q         <= d_n;
      r_q         <= r_n;
      q_q         <= q_n;
      cnt_q       <= cnt_n;
      sgn_q       <= sgn_n;
      sq_q        <= sq_n;
      sr_q        <= sr_n;
      take_q      <= take_n;
      zero_q      <= zero_n;
      lo          <= lo_n;
      hi          <= hi_n;
      div_by_zero <= dbz_n;
      done        <= done_n;
      busy        <= busy_n;
      alu_sel     <= alu_sel_n;
      alu_a       <= alu_a_n;
      alu_b       <= alu_b_n;
      alu_op      <= alu_op_n;
    end
  end

endmodule

// File: tb/tb_div_seq_ctrl.sv
// Bench for div_seq_ctrl: transaction-level divide model plus directed vectors.
module tb_div_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        is_signed = 1'b0;
  logic [31:0] dividend = '0;
  logic [31:0] divisor = '0;
  logic        abort = 1'b0;
  logic [31:0] alu_out;
  logic [31:0] alu_a, alu_b, lo, hi;
  logic [4:0]  alu_op;
  logic        alu_sel, busy, done, div_by_zero;

  int n_pass = 0;
  int n_chk  = 0;

  div_seq_ctrl #(.W(32)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .is_signed(is_signed),
    .dividend(dividend), .divisor(divisor), .abort(abort), .alu_out(alu_out),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_sel(alu_sel),
    .busy(busy), .done(done), .div_by_zero(div_by_zero), .lo(lo), .hi(hi)
  );

  always #5 clk = ~clk;

  // Stand-in for the shared EX-stage ALU
  always_comb begin
    case (alu_op)
      5'b00001: alu_out = alu_a - alu_b;
      5'b01100: alu_out = {31'b0, alu_a < alu_b};
      default:  alu_out = '0;
    endcase
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
  endtask

  task automatic chk1(input string nm, input logic act, input logic exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
  endtask

  // Architectural result of DIV/DIVU: {div_by_zero, hi, lo}
  function automatic logic [64:0] ref_div(input logic [31:0] a, input logic [31:0] b,
                                          input logic s);
    logic [31:0] ma, mb, q, r;
    if (b == 32'd0) return {1'b1, a, 32'hFFFF_FFFF};
    ma = (s && a[31]) ? -a : a;
    mb = (s && b[31]) ? -b : b;
    q  = ma / mb;
    r  = ma % mb;
    if (s && (a[31] ^ b[31])) q = -q;
    if (s && a[31])           r = -r;
    return {1'b0, r, q};
  endfunction

  // Transaction model: m_k counts edges since the accepted start edge
  logic        m_act = 1'b0;
  int          m_k = 0;
  int          m_lat = 1;
  logic [64:0] m_res = '0;
  logic        m_done = 1'b0;
  logic [31:0] m_lo = '0, m_hi = '0;
  logic        m_dbz = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_act <= 1'b0; m_k <= 0; m_done <= 1'b0;
      m_lo <= '0; m_hi <= '0; m_dbz <= 1'b0;
    end else begin
      m_done <= 1'b0;
      if (m_act) begin
        if (abort) m_act <= 1'b0;
        else if (m_k + 1 == m_lat) begin
          m_done <= 1'b1;
          m_lo   <= m_res[31:0];
          m_hi   <= m_res[63:32];
          m_dbz  <= m_res[64];
          m_act  <= 1'b0;
        end else m_k <= m_k + 1;
      end else if (start && !abort) begin
        m_act <= 1'b1;
        m_k   <= 0;
        m_res <= ref_div(dividend, divisor, is_signed);
        m_lat <= (divisor == 32'd0) ? 1 : (is_signed ? 69 : 65);
      end
    end
  end

  // Per-cycle comparison against the model
  always @(negedge clk) begin
    logic exp_busy;
    exp_busy = m_act && (m_k != m_lat - 1);
    chk1("busy", busy, exp_busy);
    chk1("alu_sel", alu_sel, exp_busy);
    chk1("done", done, m_done);
    chk("lo", lo, m_lo);
    chk("hi", hi, m_hi);
    chk1("div_by_zero", div_by_zero, m_dbz);
    if (exp_busy) chk1("alu_op_legal", (alu_op == 5'b00001) || (alu_op == 5'b01100), 1'b1);
    else begin
      chk("alu_op_idle", 32'(alu_op), 32'd0);
      chk("alu_a_idle", alu_a, 32'd0);
      chk("alu_b_idle", alu_b, 32'd0);
    end
  end

  // One divide with literal expectations; mid>0 re-pulses start at that edge
  task automatic run(input logic [31:0] a, input logic [31:0] b, input logic s,
                     input logic [31:0] el, input logic [31:0] eh, input logic ed,
                     input int elat, input int mid);
    int n;
    @(negedge clk);
    start = 1'b1; is_signed = s; dividend = a; divisor = b;
    @(negedge clk);
    start = 1'b0; dividend = $urandom; divisor = $urandom;
    n = 0;
    while (!done && n < 200) begin
      start = (mid != 0) && (n + 1 == mid);
      @(negedge clk);
      n++;
    end
    start = 1'b0;
    chk("latency", 32'(n), 32'(elat));
    chk("lo_lit", lo, el);
    chk("hi_lit", hi, eh);
    chk1("dbz_lit", div_by_zero, ed);
  endtask

  initial begin
    int pulses;
    repeat (2) @(negedge clk);
    chk("rst_lo", lo, 32'd0);
    chk("rst_hi", hi, 32'd0);
    chk("rst_alu_op", 32'(alu_op), 32'd0);
    chk1("rst_busy", busy, 1'b0);
    chk1("rst_done", done, 1'b0);
    rst_n = 1'b1;

    run(32'd100, 32'd7, 1'b0, 32'd14, 32'd2, 1'b0, 65, 0);
    run(32'hFFFF_FFF9, 32'd2, 1'b1, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0, 69, 0);
    run(32'd7, 32'hFFFF_FFFE, 1'b1, 32'hFFFF_FFFD, 32'd1, 1'b0, 69, 0);
    run(32'hFFFF_FFFF, 32'd1, 1'b0, 32'hFFFF_FFFF, 32'd0, 1'b0, 65, 0);
    run(32'hFFFF_FFFF, 32'h8000_0000, 1'b0, 32'd1, 32'h7FFF_FFFF, 1'b0, 65, 0);
    run(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'h8000_0000, 32'd0, 1'b0, 69, 0);
    run(32'd5, 32'd0, 1'b0, 32'hFFFF_FFFF, 32'd5, 1'b1, 1, 0);
    run(32'hFFFF_FFF0, 32'd0, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFF0, 1'b1, 1, 0);

    // Abort at edge 30, with a stray start at edge 10
    @(negedge clk);
    start = 1'b1; is_signed = 1'b0; dividend = 32'd1000; divisor = 32'd3;
    @(negedge clk);
    start = 1'b0;
    for (int n = 0; n < 30; n++) begin
      start = (n == 9);
      if (start) begin dividend = 32'd50; divisor = 32'd5; end
      abort = (n == 29);
      @(negedge clk);
    end
    start = 1'b0; abort = 1'b0;
    chk1("abort_busy", busy, 1'b0);
    chk("abort_lo_kept", lo, 32'hFFFF_FFFF);
    chk("abort_hi_kept", hi, 32'hFFFF_FFF0);
    pulses = 0;
    repeat (80) begin @(negedge clk); if (done) pulses++; end
    chk("abort_no_done", 32'(pulses), 32'd0);

    // abort together with start in IDLE: start ignored
    start = 1'b1; abort = 1'b1; dividend = 32'd9; divisor = 32'd3;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    @(negedge clk);
    chk1("abort_start_idle", busy, 1'b0);

    run(32'd1000, 32'd3, 1'b0, 32'd333, 32'd1, 1'b0, 65, 0);
    run(32'd200, 32'd9, 1'b0, 32'd22, 32'd2, 1'b0, 65, 20);

    // Asynchronous reset between edges mid-divide
    @(negedge clk);
    start = 1'b1; is_signed = 1'b0; dividend = 32'd100; divisor = 32'd7;
    @(negedge clk);
    start = 1'b0;
    repeat (20) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk1("arst_busy", busy, 1'b0);
    chk1("arst_alu_sel", alu_sel, 1'b0);
    chk("arst_alu_a", alu_a, 32'd0);
    chk("arst_lo", lo, 32'd0);
    chk("arst_hi", hi, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    run(32'd100, 32'd7, 1'b0, 32'd14, 32'd2, 1'b0, 65, 0);

    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/div_seq_ctrl.md
Name: div_seq_ctrl

Overview:
- Multi-cycle 32-bit integer divide sequencer for the EX stage. It implements DIV/DIVU by driving the existing single-cycle ALU through its A/B/op inputs.
- It uses ALU op 5'b00001 (sub) and 5'b01100 (sltu), and holds the results in internal HI/LO registers.
- While busy, it owns the ALU through alu_sel and stalls the pipeline.
- Restoring division: 2 ALU cycles per quotient bit, plus signed pre/post negation.

Parameters:
- W, 32, operand/result width. Only 32 is supported; the bit counter is 5 bits.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  begin divide; sampled only in IDLE
- is_signed  in  1  1 = DIV, 0 = DIVU; latched with start
- dividend  in  32  dividend (rs); latched with start
- divisor  in  32  divisor (rt); latched with start
- abort  in  1  pipeline flush; return to IDLE next cycle
- alu_out  in  32  ALU result for the current alu_op
- alu_a  out  32  ALU A operand
- alu_b  out  32  ALU B operand
- alu_op  out  5  ALU opcode
- alu_sel  out  1  1 = controller drives the ALU (EX mux select)
- busy  out  1  stall request; high in every state except IDLE and DONE
- done  out  1  one-cycle pulse; results valid
- div_by_zero  out  1  set with done when the latched divisor was 0
- lo  out  32  quotient
- hi  out  32  remainder

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE.
  - lo, hi, alu_a, alu_b = 0; alu_op = 0; alu_sel, busy, done, div_by_zero = 0.
  - Reset mid-operation discards all work.
- States: IDLE, NEGA, NEGB, CMP, SUB, FIXQ, FIXR, DONE.
- IDLE:
  - On start=1, latch N=dividend, D=divisor, sgn=is_signed. Set sq = sgn & (N[31]^D[31]) and sr = sgn & N[31]. Clear R=0 and cnt=31.
  - Next state: D==0 goes to DONE (zero path). Otherwise sgn goes to NEGA, else CMP.
- NEGA: alu_op=sub, alu_a=0, alu_b=N. If N[31], N<=alu_out. Next state NEGB.
- NEGB: same as NEGA but on D. Next state CMP.
- Shifted partial remainder: S = {R, N[cnt]} (33 bits). Let S32 = S[31:0].
- CMP:
  - alu_op=sltu, alu_a=S32, alu_b=D.
  - take <= R[31] | ~alu_out[0]. R[31]=1 means S >= 2^32 > D, so subtract unconditionally.
  - Next state SUB.
- SUB:
  - alu_op=sub, alu_a=S32, alu_b=D.
  - If take: R<=alu_out and Q[cnt]<=1. Else: R<=S32 and Q[cnt]<=0.
  - If cnt==0, next is FIXQ when sgn, else DONE. Otherwise cnt<=cnt-1 and next is CMP.
- FIXQ: alu_op=sub, alu_a=0, alu_b=Q. Q<=alu_out if sq. Next state FIXR.
- FIXR: the same operation on R using sr. Next state DONE.
- DONE:
  - done=1 for exactly one cycle.
  - On the normal path: lo<=Q, hi<=R, div_by_zero<=0.
  - On the zero path: lo<=32'hFFFFFFFF, hi<=dividend as latched, div_by_zero<=1.
  - Next state IDLE.
  - lo/hi/div_by_zero are registered and hold until the next DONE.
- Latency, counting edges after the start edge to the DONE cycle:
  - unsigned: 65 (64 ALU cycles)
  - signed: 69
  - divide-by-zero: 1
- alu_sel=1 in NEGA, NEGB, CMP, SUB, FIXQ and FIXR only. In other states alu_a=alu_b=0 and alu_op=5'b00000.
- start while busy or in DONE is ignored. It is not queued.
- abort=1 in any non-IDLE state forces IDLE on the next edge. No done pulse; lo/hi unchanged. abort has priority over every transition, including the DONE write. abort with start in IDLE: start is ignored.
- Overflow case 0x80000000 / -1 signed: the result wraps mod 2^32, giving lo=0x80000000 and hi=0.
- Remainder sign follows the dividend. Quotient truncates toward zero.

Test Plan:
- Unsigned 100 / 7: start with is_signed=0 → busy 64 cycles; done at edge 65; lo=14, hi=2, alu_sel high throughout busy.
- Signed -7 / 2 (0xFFFFFFF9, 2) → done at edge 69; lo=0xFFFFFFFD, hi=0xFFFFFFFF. Also 7 / -2 → lo=0xFFFFFFFD, hi=1.
- Large unsigned 0xFFFFFFFF / 1 → lo=0xFFFFFFFF, hi=0. Also 0xFFFFFFFF / 0x80000000 → lo=1, hi=0x7FFFFFFF. These cover the R[31] forced-take path.
- Signed overflow 0x80000000 / 0xFFFFFFFF → lo=0x80000000, hi=0. Divide by zero 5 / 0 → done at edge 1; lo=0xFFFFFFFF, hi=5, div_by_zero=1.
- abort asserted at edge 30 of a divide → IDLE at edge 31, no done, lo/hi keep previous values. A second start pulse during busy has no effect. The next start runs normally.
- rst_n low mid-divide (asynchronous, between edges) → all outputs 0 immediately; after release, a 100 / 7 divide completes correctly.
